// File: rtl/stage_memory_lsu_pkg.sv
// Shared types for the memory stage:
// access size codes, exception causes, FSM states.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [3:0] EXC_LD_MISAL = 4'd4;
   localparam logic [3:0] EXC_LD_FAULT = 4'd5;
   localparam logic [3:0] EXC_ST_MISAL = 4'd6;
   localparam logic [3:0] EXC_ST_FAULT = 4'd7;

   typedef enum logic {
      IDLE,
      WAIT
   } state_e;

endpackage

// File: rtl/stage_memory_lsu_if.sv
// Data-memory req/ack bus between the memory stage
// (master) and the data memory (slave).
interface stage_memory_lsu_if #(
   parameter int XLEN = 32
);
   logic              req;
   logic              we;
   logic [XLEN-1:0]   addr;
   logic [XLEN-1:0]   wdata;
   logic [XLEN/8-1:0] wstrb;
   logic              ack;
   logic [XLEN-1:0]   rdata;

   modport master (
      output req, we, addr, wdata, wstrb,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata, wstrb,
      output ack, rdata
   );
endinterface

// File: rtl/stage_memory_lsu_align.sv
// Byte-lane helper: misalign detect, strobes,
// store replication, load extract and extend.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        lo,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   rdata,
   output logic              misal,
   output logic [XLEN/8-1:0] wstrb,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   ldata
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   logic [2:0]      mask;
   int              nb;
   int              off;
   logic            sign;
   logic [XLEN-1:0] sh;

   always_comb begin
      mask = 3'd0;
      nb   = 1;
      unique case (funct3[1:0])
         SZ_B: begin mask = 3'd0; nb = 1; end
         SZ_H: begin mask = 3'd1; nb = 2; end
         SZ_W: begin mask = 3'd3; nb = 4; end
         SZ_D: begin
            mask = 3'd7;
            nb   = (NB < 8) ? NB : 8;
         end
      endcase
   end

   assign misal = |(lo & mask);
   assign sh    = rdata >> {lo[OW-1:0], 3'b000};
   assign sign  = ~funct3[2] & sh[nb*8-1];

   always_comb begin
      off = int'(lo[OW-1:0]);
      for (int i = 0; i < NB; i++) begin
         wstrb[i] = (i >= off) && (i < off + nb);
         // narrow stores repeat their low bytes on every lane
         wdata[i*8 +: 8] = store_data[(i % nb)*8 +: 8];
      end
   end

   always_comb begin
      for (int i = 0; i < XLEN; i++) begin
         ldata[i] = (i < nb*8) ? sh[i] : sign;
      end
   end

endmodule

// File: rtl/stage_memory_lsu.sv
// Memory stage (M->W): variable-latency dmem access,
// bounded wait, misalign traps, W-stage registers.
module stage_memory_lsu
   import lsu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_valid,
   input  logic [XLEN-1:0]   m_pc,
   input  logic [XLEN-1:0]   m_alu_result,
   input  logic [XLEN-1:0]   m_store_data,
   input  logic [4:0]        m_rd_addr,
   input  logic [4:0]        m_rs2_addr,
   input  logic              m_reg_we,
   input  logic              m_mem_we,
   input  logic              m_load,
   input  logic [2:0]        m_funct3,
   input  logic [31:0]       m_inst,
   input  logic              w_reg_we_fwd,
   input  logic [4:0]        w_rd_addr_fwd,
   input  logic [XLEN-1:0]   wb_data_fwd,
   stage_memory_lsu_if.master dmem,
   output logic              mem_stall,
   output logic [XLEN-1:0]   m_result_fwd,
   output logic              w_valid,
   output logic [XLEN-1:0]   w_pc,
   output logic [XLEN-1:0]   w_alu_result,
   output logic [XLEN-1:0]   w_mem_data,
   output logic [4:0]        w_rd_addr,
   output logic              w_reg_we,
   output logic              w_load,
   output logic [31:0]       w_inst,
   output logic              w_exc,
   output logic [3:0]        w_exc_cause
);
   localparam int OW = $clog2(XLEN/8);

   state_e            state;
   logic [7:0]        cnt;
   logic [XLEN-1:0]   sd_q;
   logic [XLEN-1:0]   sd_sel;
   logic [XLEN-1:0]   sd_use;
   logic [XLEN-1:0]   wdata;
   logic [XLEN-1:0]   ldata;
   logic [XLEN/8-1:0] wstrb;
   logic              misal;
   logic              access;
   logic              go;
   logic              in_wait;
   logic              timeout;
   logic              stall;
   logic              bypass;
   logic              exc;
   logic [3:0]        cause;

   assign access  = m_valid & (m_load | m_mem_we);
   assign go      = access & ~misal;
   assign in_wait = (state == WAIT);
   assign bypass  = w_reg_we_fwd
                  & (w_rd_addr_fwd != 5'd0)
                  & (w_rd_addr_fwd == m_rs2_addr);
   assign sd_sel  = bypass ? wb_data_fwd : m_store_data;
   // W holds a bubble during the stall, so the bypass is gone
   assign sd_use  = in_wait ? sd_q : sd_sel;
   assign timeout = in_wait & ~dmem.ack
                  & (cnt == 8'(MAX_WAIT));
   assign stall   = in_wait ? (~dmem.ack & ~timeout)
                            : (go & ~dmem.ack);
   assign exc     = (access & misal) | timeout;

   always_comb begin
      cause = 4'd0;
      if (timeout)
         cause = m_mem_we ? EXC_ST_FAULT : EXC_LD_FAULT;
      else if (access & misal)
         cause = m_mem_we ? EXC_ST_MISAL : EXC_LD_MISAL;
   end

   lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .lo        (m_alu_result[2:0]),
      .funct3    (m_funct3),
      .store_data(sd_use),
      .rdata     (dmem.rdata),
      .misal     (misal),
      .wstrb     (wstrb),
      .wdata     (wdata),
      .ldata     (ldata)
   );

   assign dmem.req   = go | in_wait;
   assign dmem.we    = m_mem_we;
   assign dmem.addr  = {m_alu_result[XLEN-1:OW], {OW{1'b0}}};
   assign dmem.wdata = wdata;
   assign dmem.wstrb = wstrb;

   assign mem_stall    = stall;
   assign m_result_fwd = m_alu_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         sd_q         <= '0;
         w_valid      <= 1'b0;
         w_pc         <= '0;
         w_alu_result <= '0;
         w_mem_data   <= '0;
         w_rd_addr    <= 5'd0;
         w_reg_we     <= 1'b0;
         w_load       <= 1'b0;
         w_inst       <= 32'd0;
         w_exc        <= 1'b0;
         w_exc_cause  <= 4'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go & ~dmem.ack) begin
                  state <= WAIT;
                  cnt   <= 8'd1;
                  sd_q  <= sd_sel;
               end
            end
            WAIT: begin
               if (dmem.ack | timeout) begin
                  state <= IDLE;
                  cnt   <= 8'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
         endcase

         if (stall) begin
            w_valid     <= 1'b0;
            w_reg_we    <= 1'b0;
            w_load      <= 1'b0;
            w_exc       <= 1'b0;
            w_exc_cause <= 4'd0;
         end else begin
            w_valid      <= m_valid;
            w_pc         <= m_pc;
            w_alu_result <= m_alu_result;
            w_mem_data   <= ldata;
            w_rd_addr    <= m_rd_addr;
            w_reg_we     <= m_reg_we & ~exc;
            w_load       <= m_load;
            w_inst       <= m_inst;
            w_exc        <= exc;
            w_exc_cause  <= cause;
         end
      end
   end

endmodule
